conv_pool_ctrl_p: RTL and testbench

Parametrised successor of the mini-system conv/pool controller. It sequences a 3x3 same-padded convolution over an IMG_H x IMG_W input image held in ROM, writing one result per pixel to RAM_CONV. It then runs a 2x2 stride-2 pooling pass from RAM_CONV into RAM_POOL. Unlike the fixed 256x256 free-running predecessor, it is start/done handshaked, re-runnable, and sized by parameters.

---
 rtl/conv_ctrl_pkg.sv | 31 +++
 rtl/conv_win_addr_gen.sv | 33 +++
 rtl/conv_pool_ctrl_p.sv | 272 +++++++++++++++++++++++++++
 tb/tb_conv_pool_ctrl_p.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared encodings and phase lengths for the parametrised conv/pool controller.
package conv_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_W  = 3'd1;
    localparam logic [2:0] ST_READ_9  = 3'd2;
    localparam logic [2:0] ST_READ_3  = 3'd3;
    localparam logic [2:0] ST_WRITE_C = 3'd4;
    localparam logic [2:0] ST_READ_P  = 3'd5;
    localparam logic [2:0] ST_WRITE_P = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [2:0] SEL_R0 = 3'b100;
    localparam logic [2:0] SEL_R1 = 3'b010;
    localparam logic [2:0] SEL_R2 = 3'b001;

    localparam int LOAD_W_CYC = 10;
    localparam int READ9_CYC  = 10;
    localparam int READ3_CYC  = 4;
    localparam int READP_CYC  = 5;

    function automatic logic [2:0] row_sel(input logic [1:0] kr);
        case (kr)
            2'd0:    row_sel = SEL_R0;
            2'd1:    row_sel = SEL_R1;
            2'd2:    row_sel = SEL_R2;
            default: row_sel = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Combinational ROM address and padding flag for one 3x3 window pixel.
// Offsets kr/kc are 0..2 and map to -1..+1 around (row, col).
module conv_win_addr_gen #(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int ADDR_BITS = 16
) (
    input  logic [ADDR_BITS-1:0] i_row,
    input  logic [ADDR_BITS-1:0] i_col,
    input  logic [1:0]           i_kr,
    input  logic [1:0]           i_kc,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic                 o_pad
);
    localparam int SW = ADDR_BITS + 2;

    logic signed [SW-1:0] w_r;
    logic signed [SW-1:0] w_c;
    logic                 w_r_out;
    logic                 w_c_out;

    // Extra headroom bits keep row-1 at row 0 negative instead of wrapping.
    assign w_r = $signed({2'b00, i_row}) + $signed({{(SW-2){1'b0}}, i_kr}) - $signed(SW'(1));
    assign w_c = $signed({2'b00, i_col}) + $signed({{(SW-2){1'b0}}, i_kc}) - $signed(SW'(1));

    assign w_r_out = w_r[SW-1] || (w_r >= $signed(SW'(IMG_H)));
    assign w_c_out = w_c[SW-1] || (w_c >= $signed(SW'(IMG_W)));
    assign o_pad   = w_r_out || w_c_out;

    assign o_addr = o_pad ? '0
                          : w_r[ADDR_BITS-1:0] * ADDR_BITS'(IMG_W) + w_c[ADDR_BITS-1:0];

endmodule

// File: rtl/conv_pool_ctrl_p.sv
// Start/done sequencer: weight load, 3x3 same-padded conv sweep, 2x2 stride-2 pool.
// Optional macro CONV_POOL_SKIP_EN adds pool_skip (latched at start) to skip pooling.
module conv_pool_ctrl_p
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef CONV_POOL_SKIP_EN
    input  logic                 pool_skip,
`endif
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] ROM_W_A,
    output logic                 ROM_W_OE,
    output logic [ADDR_BITS-1:0] ROM_IF_A,
    output logic                 ROM_IF_OE,
    output logic [2:0]           sel_w,
    output logic [2:0]           sel_if,
    output logic                 pad_en,
    output logic                 clear,
    output logic [ADDR_BITS-1:0] RAM_CONV_A,
    output logic                 RAM_CONV_WE,
    output logic                 RAM_CONV_OE,
    output logic [ADDR_BITS-1:0] RAM_POOL_A,
    output logic                 RAM_POOL_WE,
    output logic                 pool_en
);
    localparam logic [ADDR_BITS-1:0] W_A      = ADDR_BITS'(IMG_W);
    localparam logic [ADDR_BITS-1:0] HALF_W   = ADDR_BITS'(IMG_W / 2);
    localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(IMG_W - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(IMG_H - 1);
    localparam logic [ADDR_BITS-1:0] LAST_PC  = ADDR_BITS'(IMG_W / 2 - 1);
    localparam logic [ADDR_BITS-1:0] LAST_PR  = ADDR_BITS'(IMG_H / 2 - 1);
    localparam logic [3:0] LOAD_W_END = 4'(LOAD_W_CYC - 1);
    localparam logic [3:0] READ9_END  = 4'(READ9_CYC - 1);
    localparam logic [3:0] READ3_END  = 4'(READ3_CYC - 1);
    localparam logic [3:0] READP_END  = 4'(READP_CYC - 1);

    logic [2:0]           r_state;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-1:0] r_row;
    logic [ADDR_BITS-1:0] r_col;
    logic [ADDR_BITS-1:0] r_pr;
    logic [ADDR_BITS-1:0] r_pc;
    logic [2:0]           r_sel_if;
    logic                 r_pad;
    logic                 r_skip;

    logic [1:0]           w_kr;
    logic [1:0]           w_kc;
    logic [ADDR_BITS-1:0] w_pix_a;
    logic                 w_pix_pad;
    logic                 w_pix_rd;
    logic [ADDR_BITS-1:0] w_prow;
    logic [ADDR_BITS-1:0] w_pcol;
    logic                 w_skip_in;

`ifdef CONV_POOL_SKIP_EN
    assign w_skip_in = pool_skip;
`else
    assign w_skip_in = 1'b0;
`endif

    // Window offsets: READ_9 walks k=0..8 row-major, READ_3 only the new right column.
    always_comb begin
        w_kr     = 2'd0;
        w_kc     = 2'd0;
        w_pix_rd = 1'b0;
        if (r_state == ST_READ_9 && r_cnt <= 4'd8) begin
            w_pix_rd = 1'b1;
            if (r_cnt >= 4'd6) begin
                w_kr = 2'd2;
                w_kc = 2'(r_cnt - 4'd6);
            end else if (r_cnt >= 4'd3) begin
                w_kr = 2'd1;
                w_kc = 2'(r_cnt - 4'd3);
            end else begin
                w_kc = r_cnt[1:0];
            end
        end else if (r_state == ST_READ_3 && r_cnt <= 4'd2) begin
            w_pix_rd = 1'b1;
            w_kr     = r_cnt[1:0];
            w_kc     = 2'd2;
        end
    end

    conv_win_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .ADDR_BITS (ADDR_BITS)
    ) u_win_addr (
        .i_row  (r_row),
        .i_col  (r_col),
        .i_kr   (w_kr),
        .i_kc   (w_kc),
        .o_addr (w_pix_a),
        .o_pad  (w_pix_pad)
    );

    assign w_prow = (r_pr << 1) | ADDR_BITS'(r_cnt[1]);
    assign w_pcol = (r_pc << 1) | ADDR_BITS'(r_cnt[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_pr     <= '0;
            r_pc     <= '0;
            r_sel_if <= '0;
            r_pad    <= 1'b0;
            r_skip   <= 1'b0;
        end else begin
            // Qualifiers trail the read address by one cycle to match ROM latency.
            r_sel_if <= w_pix_rd ? row_sel(w_kr) : 3'b000;
            r_pad    <= w_pix_rd & w_pix_pad;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD_W;
                        r_cnt   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_pr    <= '0;
                        r_pc    <= '0;
                        r_skip  <= w_skip_in;
                    end
                end
                ST_LOAD_W: begin
                    if (r_cnt == LOAD_W_END) begin
                        r_state <= ST_READ_9;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_READ_9: begin
                    if (r_cnt == READ9_END) begin
                        r_state <= ST_WRITE_C;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_READ_3: begin
                    if (r_cnt == READ3_END) begin
                        r_state <= ST_WRITE_C;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WRITE_C: begin
                    r_cnt <= '0;
                    if (r_col < LAST_COL) begin
                        r_col   <= r_col + 1'b1;
                        r_state <= ST_READ_3;
                    end else begin
                        r_col <= '0;
                        if (r_row == LAST_ROW) begin
                            r_row   <= '0;
                            r_pr    <= '0;
                            r_pc    <= '0;
                            r_state <= r_skip ? ST_DONE : ST_READ_P;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= ST_READ_9;
                        end
                    end
                end
                ST_READ_P: begin
                    if (r_cnt == READP_END) begin
                        r_state <= ST_WRITE_P;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WRITE_P: begin
                    r_cnt   <= '0;
                    r_state <= ST_READ_P;
                    if (r_pc == LAST_PC) begin
                        r_pc <= '0;
                        if (r_pr == LAST_PR) begin
                            r_pr    <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_pr <= r_pr + 1'b1;
                        end
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_pr    <= '0;
                    r_pc    <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign sel_if = r_sel_if;
    assign pad_en = r_pad;

    always_comb begin
        done        = 1'b0;
        clear       = 1'b0;
        ROM_W_A     = '0;
        ROM_W_OE    = 1'b0;
        ROM_IF_A    = '0;
        ROM_IF_OE   = 1'b0;
        sel_w       = 3'b000;
        RAM_CONV_A  = '0;
        RAM_CONV_WE = 1'b0;
        RAM_CONV_OE = 1'b0;
        RAM_POOL_A  = '0;
        RAM_POOL_WE = 1'b0;
        pool_en     = 1'b0;
        case (r_state)
            ST_IDLE: clear = 1'b1;
            ST_LOAD_W: begin
                if (r_cnt <= 4'd8) begin
                    ROM_W_OE = 1'b1;
                    ROM_W_A  = ADDR_BITS'(r_cnt);
                end
                if (r_cnt >= 4'd7)      sel_w = SEL_R2;
                else if (r_cnt >= 4'd4) sel_w = SEL_R1;
                else if (r_cnt >= 4'd1) sel_w = SEL_R0;
            end
            ST_READ_9, ST_READ_3: begin
                ROM_IF_OE = w_pix_rd;
                ROM_IF_A  = w_pix_rd ? w_pix_a : '0;
            end
            ST_WRITE_C: begin
                RAM_CONV_WE = 1'b1;
                RAM_CONV_A  = r_row * W_A + r_col;
            end
            ST_READ_P: begin
                if (r_cnt <= 4'd3) begin
                    RAM_CONV_OE = 1'b1;
                    RAM_CONV_A  = w_prow * W_A + w_pcol;
                end
                pool_en = (r_cnt >= 4'd1);
            end
            ST_WRITE_P: begin
                RAM_POOL_WE = 1'b1;
                RAM_POOL_A  = r_pr * HALF_W + r_pc;
            end
            ST_DONE: begin
                done  = 1'b1;
                clear = 1'b1;
            end
            default: clear = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_conv_pool_ctrl_p.sv
// Directed bench for conv_pool_ctrl_p on a 4x4 image; CONV_POOL_SKIP_EN adds the skip scenario.
module tb_conv_pool_ctrl_p;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AB = 16;
    localparam int FULL_CYC = 10 + H * (11 + 5 * (W - 1)) + (H * W / 4) * 6 + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
`ifdef CONV_POOL_SKIP_EN
    logic          pool_skip = 1'b0;
`endif
    logic          busy, done, ROM_W_OE, ROM_IF_OE, clear;
    logic          RAM_CONV_WE, RAM_CONV_OE, RAM_POOL_WE, pool_en, pad_en;
    logic [AB-1:0] ROM_W_A, ROM_IF_A, RAM_CONV_A, RAM_POOL_A;
    logic [2:0]    sel_w, sel_if;

    int total = 0;
    int bad   = 0;

    // Per-run observations collected by run_pass
    int            busy_cyc, done_cnt, pool_we_cnt, pool_en_cnt, timed_out;
    int            conv_q[$];
    int            pool_q[$];
    logic [AB-1:0] tr_rom_w_a[256];
    logic [2:0]    tr_sel_w[256];
    logic [AB-1:0] tr_rom_if_a[256];
    logic          tr_rom_if_oe[256];
    logic [2:0]    tr_sel_if[256];
    logic          tr_pad[256];
    logic [AB-1:0] tr_conv_a[256];
    logic          tr_conv_oe[256];
    logic          tr_pool_en[256];
    logic [AB-1:0] tr_pool_a[256];

    always #5 clk = ~clk;

    conv_pool_ctrl_p #(.IMG_W(W), .IMG_H(H), .ADDR_BITS(AB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef CONV_POOL_SKIP_EN
        .pool_skip   (pool_skip),
`endif
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ROM_W_A     (ROM_W_A),
        .ROM_W_OE    (ROM_W_OE),
        .ROM_IF_A    (ROM_IF_A),
        .ROM_IF_OE   (ROM_IF_OE),
        .sel_w       (sel_w),
        .sel_if      (sel_if),
        .pad_en      (pad_en),
        .clear       (clear),
        .RAM_CONV_A  (RAM_CONV_A),
        .RAM_CONV_WE (RAM_CONV_WE),
        .RAM_CONV_OE (RAM_CONV_OE),
        .RAM_POOL_A  (RAM_POOL_A),
        .RAM_POOL_WE (RAM_POOL_WE),
        .pool_en     (pool_en)
    );

    // One start pulse, then trace every busy cycle; optional extra start at t=ign_t and in DONE.
    task automatic run_pass(input int ign_t, input bit ign_done);
        int t;
        t = 0; busy_cyc = 0; done_cnt = 0; pool_we_cnt = 0; pool_en_cnt = 0; timed_out = 0;
        conv_q.delete();
        pool_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (busy && t < 1000) begin
            if (t < 256) begin
                tr_rom_w_a[t]   = ROM_W_A;   tr_sel_w[t]    = sel_w;
                tr_rom_if_a[t]  = ROM_IF_A;  tr_rom_if_oe[t] = ROM_IF_OE;
                tr_sel_if[t]    = sel_if;    tr_pad[t]      = pad_en;
                tr_conv_a[t]    = RAM_CONV_A; tr_conv_oe[t] = RAM_CONV_OE;
                tr_pool_en[t]   = pool_en;   tr_pool_a[t]   = RAM_POOL_A;
            end
            busy_cyc++;
            if (RAM_CONV_WE) conv_q.push_back(int'(RAM_CONV_A));
            if (RAM_POOL_WE) begin pool_q.push_back(int'(RAM_POOL_A)); pool_we_cnt++; end
            if (pool_en) pool_en_cnt++;
            if (done) begin done_cnt++; if (ign_done) start = 1'b1; end
            if (t == ign_t) start = 1'b1;
            t++;
            @(negedge clk); start = 1'b0;
        end
        if (t >= 1000) timed_out = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (clear !== 1'b1) begin bad++; $display("FAIL reset_clear got=%b want=1", clear); end
        total++;
        if ({done, ROM_W_OE, ROM_W_A, ROM_IF_OE, ROM_IF_A, sel_w, sel_if, pad_en, RAM_CONV_A,
             RAM_CONV_WE, RAM_CONV_OE, RAM_POOL_A, RAM_POOL_WE, pool_en} !== '0) begin
            bad++; $display("FAIL reset_outputs got=nonzero want=all zero");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        run_pass(-1, 1'b0);
        total++; if (timed_out !== 0) begin bad++; $display("FAIL full_timeout got=%0d want=0", timed_out); end
        total++; if (busy_cyc !== FULL_CYC) begin bad++; $display("FAIL full_busy_cyc got=%0d want=%0d", busy_cyc, FULL_CYC); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_cnt got=%0d want=1", done_cnt); end
        for (int k = 0; k <= 8; k++) begin
            total++;
            if (tr_rom_w_a[k] !== AB'(k)) begin bad++; $display("FAIL load_w_a k=%0d got=%0d want=%0d", k, tr_rom_w_a[k], k); end
        end
        total++; if (tr_sel_w[0] !== 3'b000) begin bad++; $display("FAIL sel_w_t0 got=%b want=000", tr_sel_w[0]); end
        total++; if (tr_sel_w[1] !== 3'b100) begin bad++; $display("FAIL sel_w_t1 got=%b want=100", tr_sel_w[1]); end
        total++; if (tr_sel_w[4] !== 3'b010) begin bad++; $display("FAIL sel_w_t4 got=%b want=010", tr_sel_w[4]); end
        total++; if (tr_sel_w[9] !== 3'b001) begin bad++; $display("FAIL sel_w_t9 got=%b want=001", tr_sel_w[9]); end
    endtask

    // Corner window (0,0): addresses at t=10+k, qualifiers at t=11+k.
    task automatic test_corner();
        logic [8:0]    exp_pad;
        logic [AB-1:0] exp_a[9];
        exp_pad = 9'b001001111; // bit k: pixels 0,1,2,3,6 padded
        exp_a   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd4, 16'd5};
        for (int k = 0; k < 9; k++) begin
            total++;
            if (tr_pad[11+k] !== exp_pad[k]) begin bad++; $display("FAIL corner_pad k=%0d got=%b want=%b", k, tr_pad[11+k], exp_pad[k]); end
            total++;
            if (tr_rom_if_a[10+k] !== exp_a[k]) begin bad++; $display("FAIL corner_addr k=%0d got=%0d want=%0d", k, tr_rom_if_a[10+k], exp_a[k]); end
        end
        total++; if (tr_sel_if[11] !== 3'b100) begin bad++; $display("FAIL corner_sel_if0 got=%b want=100", tr_sel_if[11]); end
        total++; if (tr_sel_if[15] !== 3'b010) begin bad++; $display("FAIL corner_sel_if4 got=%b want=010", tr_sel_if[15]); end
        total++; if (tr_sel_if[19] !== 3'b001) begin bad++; $display("FAIL corner_sel_if8 got=%b want=001", tr_sel_if[19]); end
        total++; if (tr_rom_if_oe[10] !== 1'b1) begin bad++; $display("FAIL corner_oe got=%b want=1", tr_rom_if_oe[10]); end
        // READ_3 at (0,1) fetches column 2: (-1,2) pad, (0,2)=2, (1,2)=6
        total++; if (tr_pad[22] !== 1'b1) begin bad++; $display("FAIL r3_pad0 got=%b want=1", tr_pad[22]); end
        total++; if (tr_pad[23] !== 1'b0) begin bad++; $display("FAIL r3_pad1 got=%b want=0", tr_pad[23]); end
        total++; if (tr_rom_if_a[22] !== 16'd2) begin bad++; $display("FAIL r3_addr1 got=%0d want=2", tr_rom_if_a[22]); end
        total++; if (tr_rom_if_a[23] !== 16'd6) begin bad++; $display("FAIL r3_addr2 got=%0d want=6", tr_rom_if_a[23]); end
        total++; if (tr_sel_if[24] !== 3'b001) begin bad++; $display("FAIL r3_sel_if2 got=%b want=001", tr_sel_if[24]); end
    endtask

    task automatic test_writes();
        total++; if (conv_q.size() !== 16) begin bad++; $display("FAIL conv_wr_cnt got=%0d want=16", conv_q.size()); end
        for (int i = 0; i < 16 && i < conv_q.size(); i++) begin
            total++; if (conv_q[i] !== i) begin bad++; $display("FAIL conv_wr_a i=%0d got=%0d want=%0d", i, conv_q[i], i); end
        end
        total++; if (pool_q.size() !== 4) begin bad++; $display("FAIL pool_wr_cnt got=%0d want=4", pool_q.size()); end
        for (int i = 0; i < 4 && i < pool_q.size(); i++) begin
            total++; if (pool_q[i] !== i) begin bad++; $display("FAIL pool_wr_a i=%0d got=%0d want=%0d", i, pool_q[i], i); end
        end
    endtask

    // Window (pr=1,pc=1) is the 4th pool window, starting at t=114+18.
    task automatic test_pool_window();
        int exp_a[4];
        exp_a = '{10, 11, 14, 15};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (tr_conv_a[132+k] !== AB'(exp_a[k]) || tr_conv_oe[132+k] !== 1'b1) begin
                bad++; $display("FAIL pool_rd k=%0d got=%0d/%b want=%0d/1", k, tr_conv_a[132+k], tr_conv_oe[132+k], exp_a[k]);
            end
        end
        total++; if (tr_pool_en[132] !== 1'b0) begin bad++; $display("FAIL pool_en_c0 got=%b want=0", tr_pool_en[132]); end
        total++; if (tr_pool_en[136] !== 1'b1) begin bad++; $display("FAIL pool_en_c4 got=%b want=1", tr_pool_en[136]); end
        total++; if (tr_pool_a[137] !== 16'd3) begin bad++; $display("FAIL pool_wr_last got=%0d want=3", tr_pool_a[137]); end
        total++; if (pool_en_cnt !== 16) begin bad++; $display("FAIL pool_en_cnt got=%0d want=16", pool_en_cnt); end
    endtask

    task automatic test_start_ignored();
        run_pass(50, 1'b1);
        total++; if (busy_cyc !== FULL_CYC) begin bad++; $display("FAIL ign_busy_cyc got=%0d want=%0d", busy_cyc, FULL_CYC); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL ign_done_cnt got=%0d want=1", done_cnt); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_done_start got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        run_pass(-1, 1'b0);
        total++; if (busy_cyc !== FULL_CYC) begin bad++; $display("FAIL b2b_busy_cyc got=%0d want=%0d", busy_cyc, FULL_CYC); end
        total++; if (conv_q.size() !== 16 || conv_q[15] !== 15) begin bad++; $display("FAIL b2b_conv got=%0d want=16", conv_q.size()); end
        total++; if (pool_q.size() !== 4 || pool_q[3] !== 3) begin bad++; $display("FAIL b2b_pool got=%0d want=4", pool_q.size()); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (22) @(negedge clk);
        total++; if (ROM_IF_OE !== 1'b1 || ROM_IF_A !== 16'd2) begin bad++; $display("FAIL mid_in_read3 got=%b/%0d want=1/2", ROM_IF_OE, ROM_IF_A); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || clear !== 1'b1) begin bad++; $display("FAIL mid_rst_state got=%b/%b want=0/1", busy, clear); end
        total++;
        if ({done, ROM_W_OE, ROM_W_A, ROM_IF_OE, ROM_IF_A, sel_w, sel_if, pad_en, RAM_CONV_A,
             RAM_CONV_WE, RAM_CONV_OE, RAM_POOL_A, RAM_POOL_WE, pool_en} !== '0) begin
            bad++; $display("FAIL mid_rst_outputs got=nonzero want=all zero");
        end
        rst_n = 1'b1;
        run_pass(-1, 1'b0);
        total++; if (tr_rom_w_a[0] !== 16'd0) begin bad++; $display("FAIL mid_rerun_w_a got=%0d want=0", tr_rom_w_a[0]); end
        total++; if (busy_cyc !== FULL_CYC) begin bad++; $display("FAIL mid_rerun_cyc got=%0d want=%0d", busy_cyc, FULL_CYC); end
    endtask

`ifdef CONV_POOL_SKIP_EN
    task automatic test_pool_skip();
        pool_skip = 1'b1;
        run_pass(-1, 1'b0);
        pool_skip = 1'b0;
        total++; if (busy_cyc !== 115) begin bad++; $display("FAIL skip_busy_cyc got=%0d want=115", busy_cyc); end
        total++; if (pool_we_cnt !== 0) begin bad++; $display("FAIL skip_pool_we got=%0d want=0", pool_we_cnt); end
        total++; if (pool_en_cnt !== 0) begin bad++; $display("FAIL skip_pool_en got=%0d want=0", pool_en_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL skip_done got=%0d want=1", done_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_run();
        test_corner();
        test_writes();
        test_pool_window();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef CONV_POOL_SKIP_EN
        test_pool_skip();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
